// File: rtl/halt_dump_unit.sv
// halt_dump_unit: detects the halt instruction word, freezes the CPU, waits for
// the pipeline to drain, then streams DM words followed by RF entries over a
// valid/ready interface (one word per transfer).
// Optional build macro DUMP_CHECKSUM_EN: appends one extra word carrying the
// 32-bit running sum of every dumped word, with index MEM_WORDS+REG_WORDS.
module halt_dump_unit #(
    parameter int          MEM_WORDS    = 32,
    parameter int          REG_WORDS    = 32,
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [31:0] HALT_WORD    = 32'hFFFFFFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_i,
    output logic        halt_o,
    output logic [31:0] dm_addr_o,
    input  logic [31:0] dm_data_i,
    output logic [4:0]  rf_addr_o,
    input  logic [31:0] rf_data_i,
    output logic        dump_valid_o,
    input  logic        dump_ready_i,
    output logic [31:0] dump_data_o,
    output logic [6:0]  dump_idx_o,
    output logic        dump_done_o
);

    localparam int TOTAL_WORDS = MEM_WORDS + REG_WORDS;
`ifdef DUMP_CHECKSUM_EN
    localparam int STREAM_WORDS = TOTAL_WORDS + 1;
`else
    localparam int STREAM_WORDS = TOTAL_WORDS;
`endif
    localparam logic [6:0] LAST_IDX = 7'(STREAM_WORDS);
    localparam logic [6:0] MEM_LAST = 7'(MEM_WORDS - 1);
    localparam logic [6:0] MEM_BASE = 7'(MEM_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        DUMP_MEM,
        DUMP_REG,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  idx_q, idx_d;
    logic [15:0] drain_q, drain_d;
    logic        load, xfer, fin;
    logic [31:0] sel_data;
    logic [6:0]  rf_off;

`ifdef DUMP_CHECKSUM_EN
    logic [31:0] sum_q;
`endif

    // The freeze request follows the state directly so reset releases it at once.
    assign halt_o = (state_q != IDLE);

    // Handshake qualifiers and next-state / counter logic.
    always_comb begin
        xfer    = dump_valid_o && dump_ready_i;
        load    = ((state_q == DUMP_MEM) || (state_q == DUMP_REG)) &&
                  (idx_q < LAST_IDX) && (!dump_valid_o || dump_ready_i);
        fin     = (state_q == DUMP_REG) && (idx_q == LAST_IDX) && xfer;
        state_d = state_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (instr_i == HALT_WORD) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                // Covers DRAIN_CYCLES == 0 as well: leave on the first edge.
                if (int'(drain_q) + 1 >= DRAIN_CYCLES) begin
                    state_d = DUMP_MEM;
                    idx_d   = '0;
                end else begin
                    drain_d = drain_q + 16'd1;
                end
            end
            DUMP_MEM: begin
                if (load) begin
                    idx_d = idx_q + 7'd1;
                    if (idx_q == MEM_LAST) state_d = DUMP_REG;
                end
            end
            DUMP_REG: begin
                if (load) idx_d = idx_q + 7'd1;
                if (fin)  state_d = DONE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read-port addresses and selection of the word to be loaded next.
    always_comb begin
        rf_off    = idx_q - MEM_BASE;
        dm_addr_o = '0;
        rf_addr_o = '0;
        if (state_q == DUMP_MEM) dm_addr_o = {23'b0, idx_q, 2'b00};
        if (state_q == DUMP_REG) rf_addr_o = rf_off[4:0];
        sel_data = (state_q == DUMP_MEM) ? dm_data_i : rf_data_i;
`ifdef DUMP_CHECKSUM_EN
        // The last register word may be transferring on the same edge the
        // checksum is loaded, so fold it in here to avoid a bubble.
        if (idx_q == 7'(TOTAL_WORDS))
            sel_data = sum_q + (xfer ? dump_data_o : 32'd0);
`endif
    end

    // Control state: FSM, word index and drain counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
        end
    end

    // Output stage: holds the presented word until the consumer takes it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dump_valid_o <= 1'b0;
            dump_data_o  <= '0;
            dump_idx_o   <= '0;
            dump_done_o  <= 1'b0;
        end else begin
            if (load) begin
                dump_valid_o <= 1'b1;
                dump_data_o  <= sel_data;
                dump_idx_o   <= idx_q;
            end else if (xfer) begin
                dump_valid_o <= 1'b0;
            end
            if (fin) dump_done_o <= 1'b1;
        end
    end

`ifdef DUMP_CHECKSUM_EN
    // Running sum of every word actually handed to the consumer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sum_q <= '0;
        else if (xfer) sum_q <= sum_q + dump_data_o;
    end
`endif

endmodule

// File: tb/tb_halt_dump_unit.sv
// Directed bench for halt_dump_unit: reset/idle, basic dump, backpressure,
// repeated halt word and reset in the middle of a dump.
module tb_halt_dump_unit;

    localparam logic [31:0] HALT = 32'hFFFFFFFF;
`ifdef DUMP_CHECKSUM_EN
    localparam int STREAM_LEN = 65;
`else
    localparam int STREAM_LEN = 64;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] instr_i = 32'd0;
    logic        halt_o;
    logic [31:0] dm_addr_o;
    logic [31:0] dm_data_i;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_i;
    logic        dump_valid_o;
    logic        dump_ready_i = 1'b0;
    logic [31:0] dump_data_o;
    logic [6:0]  dump_idx_o;
    logic        dump_done_o;

    int n_cmp = 0;
    int n_bad = 0;

    halt_dump_unit dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .instr_i      (instr_i),
        .halt_o       (halt_o),
        .dm_addr_o    (dm_addr_o),
        .dm_data_i    (dm_data_i),
        .rf_addr_o    (rf_addr_o),
        .rf_data_i    (rf_data_i),
        .dump_valid_o (dump_valid_o),
        .dump_ready_i (dump_ready_i),
        .dump_data_o  (dump_data_o),
        .dump_idx_o   (dump_idx_o),
        .dump_done_o  (dump_done_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory models: DM[i] = i+1, reg[k] = 2k.
    assign dm_data_i = (dm_addr_o >> 2) + 32'd1;
    assign rf_data_i = {27'b0, rf_addr_o} << 1;

    function automatic logic [31:0] exp_word(input int k);
        if (k < 32)      return 32'(k + 1);
        else if (k < 64) return 32'((k - 32) * 2);
        else             return 32'd1520;
    endfunction

    task automatic apply_reset();
        @(posedge clk_i);
        #3 rst_i = 1'b1;
        #2 rst_i = 1'b0;
    endtask

    task automatic halt_pulse();
        @(posedge clk_i); #1 instr_i = HALT;
        @(posedge clk_i); #1 instr_i = 32'd0;
    endtask

    task automatic test_reset();
        @(posedge clk_i);
        #3 rst_i = 1'b1;
        #1;
        n_cmp++; if (halt_o !== 1'b0)       begin n_bad++; $display("FAIL rst_halt got %b want 0", halt_o); end
        n_cmp++; if (dump_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", dump_valid_o); end
        n_cmp++; if (dump_done_o !== 1'b0)  begin n_bad++; $display("FAIL rst_done got %b want 0", dump_done_o); end
        n_cmp++; if (dump_data_o !== 32'd0) begin n_bad++; $display("FAIL rst_data got %h want 0", dump_data_o); end
        n_cmp++; if (dump_idx_o !== 7'd0)   begin n_bad++; $display("FAIL rst_idx got %0d want 0", dump_idx_o); end
        n_cmp++; if (dm_addr_o !== 32'd0)   begin n_bad++; $display("FAIL rst_dm_addr got %h want 0", dm_addr_o); end
        n_cmp++; if (rf_addr_o !== 5'd0)    begin n_bad++; $display("FAIL rst_rf_addr got %0d want 0", rf_addr_o); end
        #1 rst_i = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_i); #1;
            n_cmp++; if (halt_o !== 1'b0)       begin n_bad++; $display("FAIL idle_halt cyc %0d got %b want 0", c, halt_o); end
            n_cmp++; if (dump_valid_o !== 1'b0) begin n_bad++; $display("FAIL idle_valid cyc %0d got %b want 0", c, dump_valid_o); end
            case (c % 3)
                0:       instr_i = 32'h00000013;
                1:       instr_i = 32'hFFFFFFFE;
                default: instr_i = 32'h7FFFFFFF;
            endcase
        end
        instr_i = 32'd0;
    endtask

    task automatic test_basic_dump();
        apply_reset();
        dump_ready_i = 1'b1;
        @(posedge clk_i); #1 instr_i = HALT;
        @(posedge clk_i); #1;
        n_cmp++; if (halt_o !== 1'b1) begin n_bad++; $display("FAIL basic_halt_at_N got %b want 1", halt_o); end
        instr_i = 32'd0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk_i); #1;
            n_cmp++; if (dump_valid_o !== 1'b0) begin n_bad++; $display("FAIL basic_drain_valid N+%0d got %b want 0", i, dump_valid_o); end
            n_cmp++; if (halt_o !== 1'b1)       begin n_bad++; $display("FAIL basic_drain_halt N+%0d got %b want 1", i, halt_o); end
        end
        for (int k = 0; k < STREAM_LEN; k++) begin
            @(posedge clk_i); #1;
            n_cmp++; if (dump_valid_o !== 1'b1)  begin n_bad++; $display("FAIL basic_valid k %0d got %b want 1", k, dump_valid_o); end
            n_cmp++; if (dump_idx_o !== 7'(k))   begin n_bad++; $display("FAIL basic_idx got %0d want %0d", dump_idx_o, k); end
            n_cmp++; if (dump_data_o !== exp_word(k)) begin n_bad++; $display("FAIL basic_data k %0d got %h want %h", k, dump_data_o, exp_word(k)); end
        end
        @(posedge clk_i); #1;
        n_cmp++; if (dump_valid_o !== 1'b0) begin n_bad++; $display("FAIL basic_end_valid got %b want 0", dump_valid_o); end
        n_cmp++; if (dump_done_o !== 1'b1)  begin n_bad++; $display("FAIL basic_done got %b want 1", dump_done_o); end
        n_cmp++; if (halt_o !== 1'b1)       begin n_bad++; $display("FAIL basic_end_halt got %b want 1", halt_o); end
    endtask

    task automatic test_backpressure();
        int          exp_k;
        int          cyc;
        logic        prev_stall;
        logic [6:0]  prev_idx;
        logic [31:0] prev_data;
        exp_k = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_idx = '0;
        prev_data = '0;
        apply_reset();
        dump_ready_i = 1'b1;
        halt_pulse();
        for (int c = 0; c < 600 && !dump_done_o; c++) begin
            @(posedge clk_i); #1;
            if (prev_stall) begin
                n_cmp++; if (dump_valid_o !== 1'b1 || dump_idx_o !== prev_idx || dump_data_o !== prev_data) begin
                    n_bad++; $display("FAIL bp_hold got v%b idx %0d data %h want v1 idx %0d data %h", dump_valid_o, dump_idx_o, dump_data_o, prev_idx, prev_data);
                end
            end
            if (dump_valid_o) begin
                n_cmp++; if (dump_idx_o !== 7'(exp_k)) begin n_bad++; $display("FAIL bp_idx got %0d want %0d", dump_idx_o, exp_k); end
                n_cmp++; if (dump_data_o !== exp_word(exp_k)) begin n_bad++; $display("FAIL bp_data idx %0d got %h want %h", exp_k, dump_data_o, exp_word(exp_k)); end
            end
            dump_ready_i = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            cyc++;
            prev_stall = dump_valid_o && !dump_ready_i;
            prev_idx = dump_idx_o;
            prev_data = dump_data_o;
            if (dump_valid_o && dump_ready_i) exp_k++;
        end
        n_cmp++; if (dump_done_o !== 1'b1) begin n_bad++; $display("FAIL bp_done got %b want 1", dump_done_o); end
        n_cmp++; if (exp_k !== STREAM_LEN) begin n_bad++; $display("FAIL bp_count got %0d want %0d", exp_k, STREAM_LEN); end
        dump_ready_i = 1'b1;
    endtask

    task automatic test_repeat_halt();
        int n_xfer;
        n_xfer = 0;
        apply_reset();
        dump_ready_i = 1'b1;
        instr_i = HALT;
        for (int c = 0; c < 300 && !dump_done_o; c++) begin
            @(posedge clk_i); #1;
            if (dump_valid_o) begin
                n_cmp++; if (dump_idx_o !== 7'(n_xfer)) begin n_bad++; $display("FAIL rep_idx got %0d want %0d", dump_idx_o, n_xfer); end
                n_xfer++;
            end
        end
        n_cmp++; if (dump_done_o !== 1'b1)  begin n_bad++; $display("FAIL rep_done got %b want 1", dump_done_o); end
        n_cmp++; if (n_xfer !== STREAM_LEN) begin n_bad++; $display("FAIL rep_count got %0d want %0d", n_xfer, STREAM_LEN); end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_i); #1;
            n_cmp++; if (dump_valid_o !== 1'b0) begin n_bad++; $display("FAIL rep_after_valid cyc %0d got %b want 0", c, dump_valid_o); end
            n_cmp++; if (dump_done_o !== 1'b1 || halt_o !== 1'b1) begin n_bad++; $display("FAIL rep_after_state cyc %0d got done %b halt %b want 1 1", c, dump_done_o, halt_o); end
        end
        instr_i = 32'd0;
    endtask

    task automatic test_reset_mid_dump();
        logic found;
        found = 1'b0;
        apply_reset();
        dump_ready_i = 1'b1;
        halt_pulse();
        for (int c = 0; c < 200 && !found; c++) begin
            @(posedge clk_i); #1;
            found = dump_valid_o && (dump_idx_o == 7'd20);
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL mid_reach_idx20 got %b want 1", found); end
        #2 rst_i = 1'b1;
        #1;
        n_cmp++; if (dump_valid_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid got %b want 0", dump_valid_o); end
        n_cmp++; if (halt_o !== 1'b0)       begin n_bad++; $display("FAIL mid_rst_halt got %b want 0", halt_o); end
        n_cmp++; if (dump_idx_o !== 7'd0 || dump_done_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_regs got idx %0d done %b want 0 0", dump_idx_o, dump_done_o); end
        #1 rst_i = 1'b0;
        halt_pulse();
        for (int c = 0; c < 40 && !dump_valid_o; c++) begin
            @(posedge clk_i); #1;
        end
        n_cmp++; if (dump_valid_o !== 1'b1 || dump_idx_o !== 7'd0 || dump_data_o !== 32'd1) begin
            n_bad++; $display("FAIL mid_restart got v%b idx %0d data %h want v1 idx 0 data 1", dump_valid_o, dump_idx_o, dump_data_o);
        end
        for (int k = 1; k < STREAM_LEN; k++) begin
            @(posedge clk_i); #1;
            n_cmp++; if (dump_valid_o !== 1'b1 || dump_idx_o !== 7'(k) || dump_data_o !== exp_word(k)) begin
                n_bad++; $display("FAIL mid_stream got v%b idx %0d data %h want v1 idx %0d data %h", dump_valid_o, dump_idx_o, dump_data_o, k, exp_word(k));
            end
        end
        @(posedge clk_i); #1;
        n_cmp++; if (dump_done_o !== 1'b1 || dump_valid_o !== 1'b0) begin n_bad++; $display("FAIL mid_done got done %b valid %b want 1 0", dump_done_o, dump_valid_o); end
    endtask

    initial begin
        test_reset();
        test_basic_dump();
        test_backpressure();
        test_repeat_halt();
        test_reset_mid_dump();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
